// File: rtl/alu_result_checker_if.sv
// Bus between the ALU-side stimulus/result source and the result checker.
// The master drives operations and the observed ALU result; the slave reports comparisons.
interface alu_result_checker_if #(
  parameter int CNT_W = 16
);
  logic             clr;
  logic             in_valid;
  logic [3:0]       a;
  logic [3:0]       b;
  logic [1:0]       sel;
  logic [7:0]       result;
  logic             chk_valid;
  logic             mismatch;
  logic [7:0]       expected;
  logic [CNT_W-1:0] pass_count;
  logic [CNT_W-1:0] fail_count;
  logic             err_sticky;
  logic [1:0]       ff_sel;
  logic [7:0]       ff_expected;
  logic [7:0]       ff_actual;
  logic             halted;

  modport master (
    output clr, in_valid, a, b, sel, result,
    input  chk_valid, mismatch, expected, pass_count, fail_count,
           err_sticky, ff_sel, ff_expected, ff_actual, halted
  );

  modport slave (
    input  clr, in_valid, a, b, sel, result,
    output chk_valid, mismatch, expected, pass_count, fail_count,
           err_sticky, ff_sel, ff_expected, ff_actual, halted
  );
endinterface

// File: rtl/alu_result_checker.sv
// ALU result monitor: predicts each operation's result, delays it by the ALU latency,
// compares against the observed result, and keeps counters plus a first-failure capture.
module alu_result_checker #(
  parameter int LATENCY      = 1,
  parameter int CNT_W        = 16,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input logic                clk,
  input logic                rst,
  alu_result_checker_if.slave bus
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic       vld_p [LATENCY];
  logic [1:0] sel_p [LATENCY];
  logic [7:0] exp_p [LATENCY];

  logic       vld_fin, cmp_fail, cmp_pass, load_p0;
  logic [1:0] sel_fin;
  logic [7:0] exp_fin;

  logic             chk_valid_q, mismatch_q, err_sticky_q;
  logic [7:0]       expected_q, ff_expected_q, ff_actual_q;
  logic [1:0]       ff_sel_q;
  logic [CNT_W-1:0] pass_count_q, fail_count_q;

  function automatic logic [7:0] calc_exp(input logic [3:0] a, input logic [3:0] b,
                                          input logic [1:0] sel);
    logic [7:0] ea, eb, r;
    ea = {4'b0, a};
    eb = {4'b0, b};
    r  = 8'h00;
    case (sel)
      2'b00: r = ea + eb;
      2'b01: r = ea - eb;
      2'b10: r = ea * eb;
      2'b11: r = ea & eb;
    endcase
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign vld_fin  = vld_p[LATENCY-1];
  assign sel_fin  = sel_p[LATENCY-1];
  assign exp_fin  = exp_p[LATENCY-1];
  assign cmp_fail = vld_fin && (bus.result != exp_fin);
  assign cmp_pass = vld_fin && (bus.result == exp_fin);

  // A mismatch that halts also blocks the capture on that same edge, so only
  // operations captured strictly before the halt keep draining.
  always_comb begin
    state_d = state_q;
    load_p0 = 1'b0;
    case (state_q)
      RUN:     if (STOP_ON_FAIL && cmp_fail) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
    load_p0 = bus.in_valid && (state_q == RUN) && (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst || bus.clr) state_q <= RUN;
    else                 state_q <= state_d;
  end

  // Stage p0..p(LATENCY-1): expectation pipeline, valid bits reset, payload free-running
  always_ff @(posedge clk) begin
    if (!rst || bus.clr) begin
      for (int i = 0; i < LATENCY; i++) vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= load_p0;
      for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    sel_p[0] <= bus.sel;
    exp_p[0] <= calc_exp(bus.a, bus.b, bus.sel);
    for (int i = 1; i < LATENCY; i++) begin
      sel_p[i] <= sel_p[i-1];
      exp_p[i] <= exp_p[i-1];
    end
  end

  // Compare stage: final pipeline stage against the result seen this cycle
  always_ff @(posedge clk) begin
    if (!rst || bus.clr) begin
      chk_valid_q   <= 1'b0;
      mismatch_q    <= 1'b0;
      expected_q    <= 8'h00;
      pass_count_q  <= '0;
      fail_count_q  <= '0;
      err_sticky_q  <= 1'b0;
      ff_sel_q      <= 2'b00;
      ff_expected_q <= 8'h00;
      ff_actual_q   <= 8'h00;
    end else begin
      chk_valid_q <= vld_fin;
      mismatch_q  <= cmp_fail;
      expected_q  <= vld_fin ? exp_fin : 8'h00;
      if (cmp_pass) pass_count_q <= sat_inc(pass_count_q);
      if (cmp_fail) fail_count_q <= sat_inc(fail_count_q);
      if (cmp_fail && !err_sticky_q) begin
        err_sticky_q  <= 1'b1;
        ff_sel_q      <= sel_fin;
        ff_expected_q <= exp_fin;
        ff_actual_q   <= bus.result;
      end
    end
  end

  assign bus.chk_valid   = chk_valid_q;
  assign bus.mismatch    = mismatch_q;
  assign bus.expected    = expected_q;
  assign bus.pass_count  = pass_count_q;
  assign bus.fail_count  = fail_count_q;
  assign bus.err_sticky  = err_sticky_q;
  assign bus.ff_sel      = ff_sel_q;
  assign bus.ff_expected = ff_expected_q;
  assign bus.ff_actual   = ff_actual_q;
  assign bus.halted      = (state_q == HALTED);

endmodule
